// File: rtl/glyph_layer_compositor.sv
// glyph_layer_compositor: double-buffered multi-object rect/glyph compositor with sticky collision flags
module glyph_layer_compositor #(
    parameter int                 NUM_OBJ  = 4,
    parameter int                 GLYPH_W  = 8,
    parameter int                 COORD_W  = 10,
    parameter int                 COLOR_W  = 24,
    parameter logic [COLOR_W-1:0] BG_COLOR = 24'hf8f9fa
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         bright,
    input  logic [COORD_W-1:0]                           hcount,
    input  logic [COORD_W-1:0]                           vcount,
    input  logic                                         frame_start,
    input  logic                                         cfg_we,
    input  logic [(NUM_OBJ > 1 ? $clog2(NUM_OBJ) : 1)-1:0] cfg_idx,
    input  logic [1:0]                                   cfg_mode,
    input  logic [1:0]                                   cfg_scale,
    input  logic [COORD_W-1:0]                           cfg_x,
    input  logic [COORD_W-1:0]                           cfg_y,
    input  logic [COORD_W-1:0]                           cfg_w,
    input  logic [COORD_W-1:0]                           cfg_h,
    input  logic [COLOR_W-1:0]                           cfg_color,
    input  logic [GLYPH_W*GLYPH_W-1:0]                   cfg_glyph,
    output logic [COLOR_W-1:0]                           rgb,
    output logic                                         bright_out,
    output logic [NUM_OBJ-1:0]                           coll_mask
);
    localparam int IDX_W = NUM_OBJ > 1 ? $clog2(NUM_OBJ) : 1;
    localparam int GG    = GLYPH_W * GLYPH_W;
    localparam int RW    = $clog2(GLYPH_W);
    localparam int EW    = COORD_W + 4;

    typedef struct packed {
        logic [1:0]         mode;
        logic [1:0]         scale;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] h;
        logic [COLOR_W-1:0] color;
        logic [GG-1:0]      glyph;
    } desc_t;

    desc_t              shadow_q [NUM_OBJ];
    desc_t              active_q [NUM_OBJ];
    logic [NUM_OBJ-1:0] drawn_d, drawn_q;
    logic [COLOR_W-1:0] color_q [NUM_OBJ];
    logic               bright1_q, bright2_q;
    logic [COLOR_W-1:0] rgb_d, rgb_q;
    logic [NUM_OBJ-1:0] coll_d, coll_q;

    // Writes land in the shadow set; the whole active set flips on frame_start
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (reset) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end else begin
                if (cfg_we && cfg_idx == IDX_W'(i))
                    shadow_q[i] <= {cfg_mode, cfg_scale, cfg_x, cfg_y, cfg_w, cfg_h, cfg_color, cfg_glyph};
                if (frame_start)
                    active_q[i] <= shadow_q[i];
            end
        end
    end

    for (genvar i = 0; i < NUM_OBJ; i++) begin : g_obj
        logic [EW-1:0]      ext_x, ext_y, end_x, end_y;
        logic [COORD_W-1:0] dx, dy;
        logic [RW-1:0]      row, col;
        logic               hit, pix;
        assign ext_x = active_q[i].mode == 2'b01 ? EW'(active_q[i].w) : EW'(GLYPH_W) << active_q[i].scale;
        assign ext_y = active_q[i].mode == 2'b01 ? EW'(active_q[i].h) : EW'(GLYPH_W) << active_q[i].scale;
        assign end_x = EW'(active_q[i].x) + ext_x;
        assign end_y = EW'(active_q[i].y) + ext_y;
        assign hit   = hcount >= active_q[i].x && EW'(hcount) < end_x &&
                       vcount >= active_q[i].y && EW'(vcount) < end_y;
        assign dx    = hcount - active_q[i].x;
        assign dy    = vcount - active_q[i].y;
        assign col   = RW'(dx >> active_q[i].scale);
        assign row   = RW'(dy >> active_q[i].scale);
        assign pix   = active_q[i].glyph[~{row, col}];
        assign drawn_d[i] = active_q[i].mode == 2'b01 ? hit :
                            active_q[i].mode == 2'b10 ? hit & pix :
                            active_q[i].mode == 2'b11 ? hit & ~pix : 1'b0;
    end

    // Stage 1: per-object coverage, object colours and bright
    always_ff @(posedge clk) begin
        drawn_q   <= reset ? '0 : drawn_d;
        bright1_q <= reset ? 1'b0 : bright;
        for (int i = 0; i < NUM_OBJ; i++)
            color_q[i] <= reset ? '0 : active_q[i].color;
    end

    // Stage 2 next state: priority pick (lowest index wins) and collision accumulation
    always_comb begin
        rgb_d = BG_COLOR;
        for (int i = NUM_OBJ - 1; i >= 0; i--)
            rgb_d = drawn_q[i] ? color_q[i] : rgb_d;
        rgb_d  = bright1_q ? rgb_d : BG_COLOR;
        coll_d = (frame_start ? '0 : coll_q) |
                 ((bright1_q && |(drawn_q & (drawn_q - NUM_OBJ'(1)))) ? drawn_q : '0);
    end

    // Stage 2 output registers
    always_ff @(posedge clk) begin
        rgb_q     <= reset ? BG_COLOR : rgb_d;
        bright2_q <= reset ? 1'b0 : bright1_q;
        coll_q    <= reset ? '0 : coll_d;
    end

    assign rgb        = rgb_q;
    assign bright_out = bright2_q;
    assign coll_mask  = coll_q;
endmodule
